alu_seq: RTL and testbench

//  Registered, parametrised ALU with NZCV flags and a valid/ready handshake on both sides.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_mul_iter.sv | 55 +++++
 rtl/alu_seq.sv | 135 +++++++++++++
 tb/tb_alu_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ALU shared definitions: op encodings, NZCV flag bit positions, FSM states.
// Latency: none (definitions only).
// Backpressure: n/a. Used by alu_seq and alu_mul_iter (ALU_MUL_EN build).
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_t;

    function automatic logic [3:0] make_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, low WIDTH bits of unsigned a*b (built only with ALU_MUL_EN).
// Latency: start at edge 0, done/product valid combinationally in the WIDTH-th busy cycle.
// Backpressure: none; the caller starts it only when its output slot is free.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic             busy;
    logic [WIDTH-1:0] step;

    // The last partial product is folded in combinationally so the caller
    // can register the final product on the same edge the count expires.
    assign step    = acc + (mplier[0] ? mcand : '0);
    assign product = step;
    assign done    = busy && (cnt == CW'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= CW'(WIDTH);
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU (ADD/SUB/AND/ORR/EOR, MUL with ALU_MUL_EN) with NZCV flags.
// Latency: 1 cycle accept->out_valid; MUL takes WIDTH+1 cycles when ALU_MUL_EN is defined.
// Backpressure: valid/ready both sides; result held and in_ready low while out_valid & ~out_ready.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       alu_flags,
    output logic             illegal_op
);

    logic             accept;
    logic             idle;
    logic             is_mul;
    logic             is_sub;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] res_d;
    logic             c_d;
    logic             v_d;
    logic             ill_d;
    logic [3:0]       flags_d;

    // in_ready is forced low while reset is asserted, not only after it.
    assign in_ready = reset_n && idle && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

`ifdef ALU_MUL_EN
    state_t           state;
    state_t           state_nx;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;

    assign is_mul = (alu_control == ALU_MUL);
    assign idle   = (state == ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (accept && is_mul) state_nx = ST_MUL_BUSY;
            ST_MUL_BUSY: if (mul_done)         state_nx = ST_IDLE;
            default:                           state_nx = ST_IDLE;
        endcase
    end

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    assign is_mul = 1'b0;
    assign idle   = 1'b1;
`endif

    always_comb begin
        is_sub  = (alu_control == ALU_SUB);
        b_op    = is_sub ? ~b : b;
        sum_ext = {1'b0, a} + {1'b0, b_op} + (WIDTH+1)'(is_sub);
        res_d   = '0;
        c_d     = 1'b0;
        v_d     = 1'b0;
        ill_d   = 1'b0;
        case (alu_control)
            ALU_ADD: begin
                res_d = sum_ext[WIDTH-1:0];
                c_d   = sum_ext[WIDTH];
                v_d   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                res_d = sum_ext[WIDTH-1:0];
                c_d   = sum_ext[WIDTH];
                v_d   = (a[WIDTH-1] != b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: res_d = a & b;
            ALU_ORR: res_d = a | b;
            ALU_EOR: res_d = a ^ b;
            default: ill_d = 1'b1;
        endcase
        flags_d = make_flags(res_d[WIDTH-1], (res_d == '0), c_d, v_d);
    end

    // An accepted MUL does not load the output; it only frees the slot,
    // which is why the out_ready branch still clears out_valid in that case.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            result     <= '0;
            alu_flags  <= '0;
            illegal_op <= 1'b0;
        end else if (accept && !is_mul) begin
            out_valid  <= 1'b1;
            result     <= res_d;
            alu_flags  <= flags_d;
            illegal_op <= ill_d;
        end
`ifdef ALU_MUL_EN
        else if (mul_done) begin
            out_valid  <= 1'b1;
            result     <= mul_prod;
            alu_flags  <= make_flags(mul_prod[WIDTH-1], (mul_prod == '0), 1'b0, 1'b0);
            illegal_op <= 1'b0;
        end
`endif
        else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=8: vector table plus backpressure, MUL and reset sequences.
// Expected results are queued at drive time and compared when the output handshake fires.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   alu_control;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   alu_flags;
    logic         illegal_op;

    alu_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .alu_control (alu_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .alu_flags   (alu_flags),
        .illegal_op  (illegal_op)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [W-1:0] res;
        logic [3:0]   flg;
        logic         ill;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   flg;
        logic         ill;
    } exp_t;

    exp_t exp_q[$];
    int   pop_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    vec_t vecs[13];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Output monitor: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        #1;
        if (reset_n && out_valid && out_ready) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 32'(result), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("flags", 32'(alu_flags), 32'(e.flg));
                chk("illegal_op", 32'(illegal_op), 32'(e.ill));
            end
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [2:0] top,
                        input logic [W-1:0] er, input logic [3:0] ef, input logic ei,
                        input bit lat1);
        exp_t e;
        int   n;
        @(negedge clk);
        a           = ta;
        b           = tb;
        alu_control = top;
        in_valid    = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_time", 32'(n < 100), 32'd1);
        e.res = er;
        e.flg = ef;
        e.ill = ei;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (lat1) chk("latency1_out_valid", 32'(out_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;

        vecs[0]  = '{8'h7F, 8'h01, 3'b000, 8'h80, 4'b1001, 1'b0};
        vecs[1]  = '{8'h05, 8'h05, 3'b001, 8'h00, 4'b0110, 1'b0};
        vecs[2]  = '{8'h03, 8'h05, 3'b001, 8'hFE, 4'b1000, 1'b0};
        vecs[3]  = '{8'hFF, 8'h01, 3'b000, 8'h00, 4'b0110, 1'b0};
        vecs[4]  = '{8'hF0, 8'hFF, 3'b100, 8'h0F, 4'b0000, 1'b0};
        vecs[5]  = '{8'hF0, 8'h3C, 3'b010, 8'h30, 4'b0000, 1'b0};
        vecs[6]  = '{8'h00, 8'h00, 3'b011, 8'h00, 4'b0100, 1'b0};
        vecs[7]  = '{8'hA5, 8'h5A, 3'b110, 8'h00, 4'b0100, 1'b1};
        vecs[8]  = '{8'hFF, 8'hFF, 3'b111, 8'h00, 4'b0100, 1'b1};
        vecs[9]  = '{8'h80, 8'h01, 3'b001, 8'h7F, 4'b0011, 1'b0};
        vecs[10] = '{8'h80, 8'h80, 3'b000, 8'h00, 4'b0111, 1'b0};
        vecs[11] = '{8'h00, 8'h01, 3'b001, 8'hFF, 4'b1000, 1'b0};
        vecs[12] = '{8'h0F, 8'h30, 3'b011, 8'h3F, 4'b0000, 1'b0};

        reset_n     = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        a           = '0;
        b           = '0;
        alu_control = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_flags", 32'(alu_flags), 32'd0);
        chk("reset_illegal", 32'(illegal_op), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);

        // Table: back-to-back with the consumer always ready.
        for (int i = 0; i < 13; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].flg, vecs[i].ill, 1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Backpressure: result held for 5 cycles, then 3 back-to-back ops.
        out_ready = 1'b0;
        send(8'h01, 8'h02, 3'b000, 8'h03, 4'b0000, 1'b0, 1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_result", 32'(result), 32'h03);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #2;
        base = pop_cyc.size();
        send(8'h10, 8'h20, 3'b000, 8'h30, 4'b0000, 1'b0, 1'b1);
        send(8'h10, 8'h20, 3'b001, 8'hF0, 4'b1000, 1'b0, 1'b1);
        send(8'hAA, 8'h55, 3'b100, 8'hFF, 4'b1000, 1'b0, 1'b1);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("b2b_count", 32'(pop_cyc.size() - base), 32'd3);
        if (pop_cyc.size() >= base + 3) begin
            chk("b2b_gap1", 32'(pop_cyc[base+1] - pop_cyc[base]), 32'd1);
            chk("b2b_gap2", 32'(pop_cyc[base+2] - pop_cyc[base+1]), 32'd1);
        end

        // Multiply, or the reserved-op behaviour of 101 without the multiplier.
`ifdef ALU_MUL_EN
        send(8'h0C, 8'h0B, 3'b101, 8'h84, 4'b1000, 1'b0, 1'b0);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 50) begin
            chk("mul_busy_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            n++;
        end
        chk("mul_latency", 32'(n), 32'd9);
`else
        send(8'h0C, 8'h0B, 3'b101, 8'h00, 4'b0100, 1'b1, 1'b1);
        in_valid = 1'b0;
`endif
        repeat (2) @(negedge clk);

        // Reset asserted 3 cycles after accepting a 101 op; nothing may be emitted.
        out_ready = 1'b0;
        @(negedge clk);
        a           = 8'h0C;
        b           = 8'h0B;
        alu_control = 3'b101;
        in_valid    = 1'b1;
        #1;
        chk("mid_reset_accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("mid_reset_out_valid", 32'(out_valid), 32'd0);
        chk("mid_reset_in_ready", 32'(in_ready), 32'd0);
        chk("mid_reset_result", 32'(result), 32'd0);
        chk("mid_reset_illegal", 32'(illegal_op), 32'd0);
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("after_reset_in_ready", 32'(in_ready), 32'd1);
        send(8'h01, 8'h02, 3'b000, 8'h03, 4'b0000, 1'b0, 1'b1);
        in_valid = 1'b0;
        repeat (WIDTH_WAIT()) @(negedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic int WIDTH_WAIT();
        return W + 4;
    endfunction

endmodule
